// File: rtl/regfile_2r1w.sv
// 8 x 16 register file for decode: two combinational read ports, one writeback port,
// optional same-cycle write-to-read forwarding, and a sticky flag for unknown write controls.
module regfile_2r1w #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr1,
    input  logic [ADDR_BITS-1:0] rd_addr2,
    input  logic                 bypass_en,
    output logic [WIDTH-1:0]     rd_data1,
    output logic [WIDTH-1:0]     rd_data2,
    output logic                 err
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [DEPTH-1:0][WIDTH-1:0] mem_s;
    logic [DEPTH-1:0]            entry_we_s;
    logic                        wr_x_s;
    logic                        wr_ok_s;
    logic                        err_r;

    // Detect a write whose enable, or whose address while enabled, is not a clean 0/1
    always_comb begin
        wr_x_s = 1'b0;
        if ($isunknown(wr_en)) begin
            wr_x_s = 1'b1;
        end else if (wr_en && $isunknown(wr_addr)) begin
            wr_x_s = 1'b1;
        end else begin
            wr_x_s = 1'b0;
        end
    end

    // A corrupted or reset-coincident write never reaches the storage
    assign wr_ok_s = wr_en && !wr_x_s && !rst;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            logic [WIDTH-1:0] word_r;

            assign entry_we_s[i] = wr_ok_s && (wr_addr == ADDR_BITS'(i));
            assign mem_s[i]      = word_r;

            // Recirculating-enable storage word for one architectural register
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    word_r <= {WIDTH{1'b0}};
                end else if (entry_we_s[i]) begin
                    word_r <= wr_data;
                end else begin
                    word_r <= word_r;
                end
            end
        end
    endgenerate

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (wr_x_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;

    // Read port 1: reset forces zero, then forwarding, then stored value
    always_comb begin
        rd_data1 = {WIDTH{1'b0}};
        if (rst) begin
            rd_data1 = {WIDTH{1'b0}};
        end else if (bypass_en && wr_en && (rd_addr1 == wr_addr)) begin
            rd_data1 = wr_data;
        end else begin
            rd_data1 = mem_s[rd_addr1];
        end
    end

    // Read port 2: same priority as port 1
    always_comb begin
        rd_data2 = {WIDTH{1'b0}};
        if (rst) begin
            rd_data2 = {WIDTH{1'b0}};
        end else if (bypass_en && wr_en && (rd_addr2 == wr_addr)) begin
            rd_data2 = wr_data;
        end else begin
            rd_data2 = mem_s[rd_addr2];
        end
    end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- 8-entry x 16-bit general-purpose register file for the pipelined processor's decode stage.
- Owns the read side of the architectural register state: two asynchronous read ports feed decode, one write port is driven by writeback.
- Write-before-read bypass lets an instruction in decode see the value being written back in the same cycle, so the hazard unit does not need an extra stall.
- Built from recirculating-enable 16-bit register storage; one storage word per entry.

Parameters:
- WIDTH, 16, data width of each register and of all data ports.
- ADDR_BITS, 3, register index width; entry count is 2^ADDR_BITS (8).

Ports:
- clk  input  1  system clock; all storage updates on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears all entries.
- wr_en  input  1  write enable from writeback.
- wr_addr  input  ADDR_BITS  destination register index.
- wr_data  input  WIDTH  value to write.
- rd_addr1  input  ADDR_BITS  read port 1 index (Rs).
- rd_addr2  input  ADDR_BITS  read port 2 index (Rt).
- bypass_en  input  1  1 = forward wr_data to matching reads in the same cycle; 0 = raw array contents.
- rd_data1  output  WIDTH  read port 1 data.
- rd_data2  output  WIDTH  read port 2 data.
- err  output  1  registered; set when a write is attempted with X/Z on wr_addr or wr_en.

Behaviour:
- Reset:
  - rst high clears all 8 entries to 16'h0000 and err to 0 immediately, without waiting for a clock edge.
  - While rst is high, rd_data1 and rd_data2 read 16'h0000 regardless of address, and bypass is suppressed.
  - Writes presented while rst is high are discarded.
- Storage:
  - Each entry is a WIDTH-bit register with a recirculating enable (hold when not selected).
  - Entry[wr_addr] loads wr_data on the rising clk edge when wr_en=1.
  - All other entries hold.
  - No register is hardwired to zero; R0 is writable.
- Write latency: wr_data appears in the array 1 cycle after the edge where wr_en=1.
- Read (combinational, 0 cycles):
  - rd_dataN = array[rd_addrN].
  - Override: if bypass_en=1 and wr_en=1 and rd_addrN == wr_addr, then rd_dataN = wr_data in the same cycle.
  - Both ports may address the same entry; both must return identical data.
  - Both ports may bypass simultaneously.
  - With bypass_en=0, a same-cycle read of the entry being written returns the old value; the new value is visible the cycle after the edge.
- Back-to-back writes: consecutive cycles writing the same address leave the last value; each intermediate value is visible through bypass in its own cycle.
- err:
  - Sampled on the rising edge: set if wr_en is X/Z, or if wr_en=1 and wr_addr contains X/Z.
  - Sticky until rst.
  - The corrupted write is dropped; no entry changes.
  - Simulation-only check; err synthesizes to constant 0.
- Reset mid-operation: rst asserting in the same cycle as wr_en=1 wins; the entry stays 0.
- No other state; no sequencing beyond per-entry write enable.

Test Plan:
- Reset, then read all 8 addresses on both ports: every read returns 16'h0000 and err=0.
- Write and read back:
  - Write R3=16'hBEEF with bypass_en=0, reading rd_addr1=3 in the same cycle: rd_data1=16'h0000 that cycle and 16'hBEEF the next.
  - Repeat with bypass_en=1: rd_data1=16'hBEEF in the same cycle.
- Write R5=16'h1234, then present rd_addr1=5, rd_addr2=5: both ports return 16'h1234. Then write R5=16'hFFFF with bypass_en=1: both return 16'hFFFF the same cycle.
- Fill and hold:
  - Fill R0..R7 with 16'h1111*index (R7=16'h7777), then hold wr_en=0 for 10 cycles with random wr_addr/wr_data: all values unchanged.
  - Check R0=16'h0000 only because 0*16'h1111=0; then write R0=16'hA5A5 and read 16'hA5A5.
- Asynchronous reset:
  - Pulse rst mid-cycle (between edges) after filling the array: all reads drop to 0 before the next edge.
  - Then assert rst with wr_en=1, wr_addr=2, wr_data=16'hCAFE: R2 reads 16'h0000 after rst releases.
- Drive wr_en=1 with wr_addr=3'bx1x for one edge: err=1 from the next cycle, all entries unchanged, err stays 1 until rst.
